dataram_ws: RTL

//   Parametrised successor to the testbench data memory: word-organised RAM with byte-write strobes.

---
 rtl/dataram_ws.sv | 117 +++++++++++
 1 files changed

// File: rtl/dataram_ws.sv
// dataram_ws: word-organised RAM with byte-write strobes, a req/ready/rvalid
// handshake and a fixed number of wait states between accept and response.
// Used as a slow data memory so that core stall logic sees non-zero latency.
module dataram_ws #(
  parameter int    DATA_WIDTH = 32,
  parameter int    BUS_WIDTH  = 17,
  parameter int    LATENCY    = 2,
  parameter string INIT_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [BUS_WIDTH-1:0]    adr,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic                    ready,
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    err
);

  localparam int         NB    = DATA_WIDTH / 8;
  localparam int         DEPTH = 1 << (BUS_WIDTH - 2);
  localparam logic [3:0] LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q;
  logic                  we_q;
  logic [NB-1:0]         be_q;
  logic [BUS_WIDTH-1:0]  adr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  do_resp;
  logic                  cur_we;
  logic                  cur_mis;
  logic [NB-1:0]         cur_be;
  logic [BUS_WIDTH-3:0]  cur_idx;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] new_word;

  assign accept  = ready && req && (state_q == S_IDLE);
  assign do_resp = (state_d == S_RESP);

  // Next-state logic: IDLE -> WAIT (counting) -> RESP -> IDLE; WAIT skipped when LATENCY=0.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt_q == 4'd1) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Select the live transaction (raw inputs when responding straight from IDLE) and merge the write bytes.
  always_comb begin
    cur_we    = (state_q == S_IDLE) ? we        : we_q;
    cur_be    = (state_q == S_IDLE) ? be        : be_q;
    cur_wdata = (state_q == S_IDLE) ? writedata : wdata_q;
    cur_idx   = (state_q == S_IDLE) ? adr[BUS_WIDTH-1:2] : adr_q[BUS_WIDTH-1:2];
    cur_mis   = (state_q == S_IDLE) ? (|adr[1:0])        : (|adr_q[1:0]);
    old_word  = mem[cur_idx];
    new_word  = old_word;
    if (cur_we) begin
      for (int i = 0; i < NB; i++) begin
        if (cur_be[i]) new_word[8*i +: 8] = cur_wdata[8*i +: 8];
      end
    end
  end

  // Handshake state, wait-state counter, request capture and response registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q  <= S_IDLE;
      ready    <= 1'b0;
      rvalid   <= 1'b0;
      err      <= 1'b0;
      readdata <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      adr_q    <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      ready   <= (state_d == S_IDLE);
      rvalid  <= do_resp;
      err     <= do_resp && cur_mis;
      if (accept) begin
        we_q    <= we;
        be_q    <= be;
        adr_q   <= adr;
        wdata_q <= writedata;
        cnt_q   <= LAT;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (do_resp) readdata <= cur_mis ? '0 : new_word;
    end
  end

  // Commit the merged word on the edge that enters RESP; misaligned writes are dropped.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; its contents survive reset and a reset never writes it.
    if (do_resp && cur_we && !cur_mis) mem[cur_idx] <= new_word;
  end

endmodule
